// File: rtl/serial_io_shell_pkg.sv
// serial_io_shell_pkg: frame sizing and saturating-count helpers shared by the shell.
package serial_io_shell_pkg;
  function automatic int words(input int width, input int lanes);
    return (width + lanes - 1) / lanes;
  endfunction
  function automatic int cnt_w(input int n_words);
    return $clog2(n_words + 1);
  endfunction
  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction
endpackage

// File: rtl/serial_io_shell_if.sv
// serial_io_shell_if: operand/control/result bundle between the shell (slave) and its driver (master).
// d/de/ctl: serial operand, load enable, control; qe/core_r: result capture.
// core_din/core_ctl/din_stb: latched operand to the core; frame_full, q: status and reduced pin.
interface serial_io_shell_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1,
  parameter int CTL_W = 2
);
  logic [LANES-1:0] d;
  logic             de;
  logic [CTL_W-1:0] ctl;
  logic             qe;
  logic [WIDTH-1:0] core_r;
  logic [WIDTH-1:0] core_din;
  logic [CTL_W-1:0] core_ctl;
  logic             din_stb;
  logic             frame_full;
  logic             q;
  modport master (output d, de, ctl, qe, core_r, input core_din, core_ctl, din_stb, frame_full, q);
  modport slave (input d, de, ctl, qe, core_r, output core_din, core_ctl, din_stb, frame_full, q);
endinterface

// File: rtl/serial_io_shell_deser.sv
// serial_io_deser: LANES-wide shift register with frame counter and load strobe.
// i_d: newest group (lane 0 = LSB); i_de: external load; o_dd: pre-shift register;
// o_frame_full: WORDS groups since last load; o_ld: load strobe (external or auto).
module serial_io_deser import serial_io_shell_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter int AUTO_LOAD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] i_d,
  input  logic             i_de,
  output logic [WIDTH-1:0] o_dd,
  output logic             o_frame_full,
  output logic             o_ld
);
  localparam int WORDS = words(WIDTH, LANES);
  localparam int CNT_W = cnt_w(WORDS);
  logic [WIDTH-1:0] r_dd;
  logic [CNT_W-1:0] r_fill;
  logic [WIDTH-1:0] w_dd_nxt;
  // Bits above WIDTH fall off, so a non-multiple width truncates the oldest group.
  if (LANES == WIDTH) begin : g_full
    assign w_dd_nxt = i_d;
  end else begin : g_shift
    assign w_dd_nxt = {r_dd[WIDTH-1-LANES:0], i_d};
  end
  assign o_frame_full = r_fill == CNT_W'(WORDS);
  assign o_ld         = i_de | ((AUTO_LOAD != 0) & o_frame_full);
  assign o_dd         = r_dd;
  // A load restarts the count at 1: the group shifted in on the load cycle opens the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dd   <= '0;
      r_fill <= '0;
    end else begin
      r_dd   <= w_dd_nxt;
      r_fill <= o_ld ? CNT_W'(1) : CNT_W'(sat_inc(32'(r_fill), WORDS));
    end
  end
endmodule

// File: rtl/serial_io_shell.sv
// serial_io_shell: pin-limited I/O wrapper feeding a wide core and reducing its result to one pin.
// clk, reset (sync, active-high); bus: serial_io_shell_if.slave carrying d/de/ctl/qe/core_r in and
// core_din/core_ctl/din_stb/frame_full/q out.
// SERIAL_IO_SHELL_SHIFT_OUT_EN: q shifts the captured result out LSB-first instead of OR-reducing it.
module serial_io_shell import serial_io_shell_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter int CTL_W     = 2,
  parameter int AUTO_LOAD = 0
) (
  input logic           clk,
  input logic           reset,
  serial_io_shell_if.slave bus
);
  logic [WIDTH-1:0] w_dd;
  logic             w_ld;
  logic [WIDTH-1:0] r_din;
  logic [CTL_W-1:0] r_ctl;
  logic             r_stb;
  logic             r_q;
  // Kept so synthesis cannot trace the core away through the single output pin.
  (* keep = "true" *) logic [WIDTH-1:0] r_qq;
  serial_io_deser #(.WIDTH(WIDTH), .LANES(LANES), .AUTO_LOAD(AUTO_LOAD)) u_deser (
    .clk          (clk),
    .reset        (reset),
    .i_d          (bus.d),
    .i_de         (bus.de),
    .o_dd         (w_dd),
    .o_frame_full (bus.frame_full),
    .o_ld         (w_ld)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_din <= '0;
      r_ctl <= '0;
      r_stb <= 1'b0;
      r_qq  <= '0;
      r_q   <= 1'b0;
    end else begin
      if (w_ld) begin
        r_din <= w_dd;
        r_ctl <= bus.ctl;
      end
      r_stb <= w_ld;
`ifdef SERIAL_IO_SHELL_SHIFT_OUT_EN
      r_qq  <= bus.qe ? bus.core_r : r_qq >> 1;
      r_q   <= r_qq[0];
`else
      if (bus.qe) r_qq <= bus.core_r;
      r_q   <= |r_qq;
`endif
    end
  end
  assign bus.core_din = r_din;
  assign bus.core_ctl = r_ctl;
  assign bus.din_stb  = r_stb;
  assign bus.q        = r_q;
endmodule

// File: tb/tb_serial_io_shell.sv
// tb_serial_io_shell: two shells (1 lane manual load, 4 lanes auto load) against a history-based model.
module tb_serial_io_shell;
  localparam int W   = 32;
  localparam int L0  = 1;
  localparam int L1  = 4;
  localparam int WD0 = 32;
  localparam int WD1 = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic de = 1'b0;
  logic qe = 1'b0;
  logic [1:0] ctl = '0;
  logic [W-1:0] core_r = '0;
  logic d0 = 1'b0;
  logic [3:0] d1 = '0;
  always #5 clk = ~clk;
  serial_io_shell_if #(.WIDTH(W), .LANES(L0), .CTL_W(2)) if0 ();
  serial_io_shell_if #(.WIDTH(W), .LANES(L1), .CTL_W(2)) if1 ();
  assign if0.d = d0;
  assign if0.de = de;
  assign if0.ctl = ctl;
  assign if0.qe = qe;
  assign if0.core_r = core_r;
  assign if1.d = d1;
  assign if1.de = de;
  assign if1.ctl = ctl;
  assign if1.qe = qe;
  assign if1.core_r = core_r;
  serial_io_shell #(.WIDTH(W), .LANES(L0), .CTL_W(2), .AUTO_LOAD(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  serial_io_shell #(.WIDTH(W), .LANES(L1), .CTL_W(2), .AUTO_LOAD(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  int n_vec = 0;
  int n_err = 0;
  int unsigned hist [2][32];
  int since [2];
  logic [W-1:0] edin [2];
  logic [1:0] ectl [2];
  logic estb [2];
  logic [W-1:0] mqq = '0;
  logic eq = 1'b0;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic logic [W-1:0] frame(input int i);
    logic [63:0] acc;
    int lanes;
    int nw;
    acc = '0;
    lanes = (i == 0) ? L0 : L1;
    nw = (i == 0) ? WD0 : WD1;
    for (int k = 0; k < nw; k++) acc = acc | (64'(hist[i][k]) << (k * lanes));
    return acc[W-1:0];
  endfunction
  function automatic int nwords(input int i);
    return (i == 0) ? WD0 : WD1;
  endfunction
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit ld;
      ld = de || (i == 1 && since[i] >= nwords(i));
      if (reset) begin
        since[i] = 0;
        edin[i] = '0;
        ectl[i] = '0;
        estb[i] = 1'b0;
        for (int k = 0; k < 32; k++) hist[i][k] = 0;
      end else begin
        if (ld) begin
          edin[i] = frame(i);
          ectl[i] = ctl;
        end
        estb[i] = ld;
        since[i] = ld ? 1 : (since[i] >= nwords(i) ? nwords(i) : since[i] + 1);
        for (int k = 31; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = (i == 0) ? 32'(d0) : 32'(d1);
      end
    end
    if (reset) begin
      mqq = '0;
      eq = 1'b0;
    end else begin
`ifdef SERIAL_IO_SHELL_SHIFT_OUT_EN
      eq = mqq[0];
      mqq = qe ? core_r : mqq >> 1;
`else
      eq = |mqq;
      if (qe) mqq = core_r;
`endif
    end
  endtask
  task automatic compare();
    chk("u0.core_din", 64'(if0.core_din), 64'(edin[0]));
    chk("u0.core_ctl", 64'(if0.core_ctl), 64'(ectl[0]));
    chk("u0.din_stb", 64'(if0.din_stb), 64'(estb[0]));
    chk("u0.frame_full", 64'(if0.frame_full), 64'(since[0] >= WD0));
    chk("u0.q", 64'(if0.q), 64'(eq));
    chk("u1.core_din", 64'(if1.core_din), 64'(edin[1]));
    chk("u1.core_ctl", 64'(if1.core_ctl), 64'(ectl[1]));
    chk("u1.din_stb", 64'(if1.din_stb), 64'(estb[1]));
    chk("u1.frame_full", 64'(if1.frame_full), 64'(since[1] >= WD1));
    chk("u1.q", 64'(if1.q), 64'(eq));
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask
  initial begin
    logic [31:0] pat;
    logic [7:0] a5;
    for (int i = 0; i < 2; i++) begin
      since[i] = 0;
      edin[i] = '0;
      ectl[i] = '0;
      estb[i] = 1'b0;
      for (int k = 0; k < 32; k++) hist[i][k] = 0;
    end
    step();
    step();
    chk("lit.reset_din", 64'(if0.core_din), 64'h0);
    chk("lit.reset_ff", 64'(if1.frame_full), 64'h0);
    reset = 1'b0;
    pat = 32'hDEADBEEF;
    for (int b = 31; b >= 0; b--) begin
      d0 = pat[b];
      d1 = 4'($urandom);
      step();
    end
    chk("lit.u0_full32", 64'(if0.frame_full), 64'h1);
    d0 = 1'b0;
    de = 1'b1;
    ctl = 2'b10;
    step();
    de = 1'b0;
    chk("lit.u0_din", 64'(if0.core_din), 64'hDEADBEEF);
    chk("lit.u0_stb", 64'(if0.din_stb), 64'h1);
    chk("lit.u0_ctl", 64'(if0.core_ctl), 64'h2);
    step();
    chk("lit.u0_stb_off", 64'(if0.din_stb), 64'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      d1 = 4'(n);
      step();
    end
    chk("lit.u1_full8", 64'(if1.frame_full), 64'h1);
    d1 = 4'h9;
    step();
    chk("lit.u1_din", 64'(if1.core_din), 64'h12345678);
    chk("lit.u1_stb", 64'(if1.din_stb), 64'h1);
    chk("lit.u1_ff_after", 64'(if1.frame_full), 64'h0);
    for (int n = 0; n < 6; n++) begin
      d1 = 4'($urandom);
      step();
    end
    chk("lit.u1_ff7", 64'(if1.frame_full), 64'h0);
    step();
    chk("lit.u1_ff8", 64'(if1.frame_full), 64'h1);
    de = 1'b1;
    step();
    de = 1'b0;
    chk("lit.both_stb", 64'(if1.din_stb), 64'h1);
    chk("lit.both_ff", 64'(if1.frame_full), 64'h0);
    step();
    chk("lit.both_single", 64'(if1.din_stb), 64'h0);
`ifdef SERIAL_IO_SHELL_SHIFT_OUT_EN
    a5 = 8'hA5;
    core_r = 32'h000000A5;
    qe = 1'b1;
    step();
    qe = 1'b0;
    core_r = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("lit.shift_bit", 64'(if0.q), 64'(a5[i]));
    end
    step();
    chk("lit.shift_done", 64'(if0.q), 64'h0);
`else
    a5 = 8'h00;
    core_r = '0;
    qe = 1'b1;
    step();
    qe = 1'b0;
    step();
    step();
    chk("lit.q_zero", 64'(if0.q), 64'(a5[0]));
    core_r = 32'h00010000;
    qe = 1'b1;
    step();
    qe = 1'b0;
    core_r = '0;
    chk("lit.q_lat1", 64'(if0.q), 64'h0);
    step();
    chk("lit.q_lat2", 64'(if0.q), 64'h1);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      d1 = 4'($urandom);
      step();
    end
    core_r = 32'hFFFF0000;
    qe = 1'b1;
    reset = 1'b1;
    de = 1'b1;
    step();
    reset = 1'b0;
    de = 1'b0;
    qe = 1'b0;
    chk("lit.rst_din", 64'(if1.core_din), 64'h0);
    chk("lit.rst_stb", 64'(if1.din_stb), 64'h0);
    chk("lit.rst_q", 64'(if1.q), 64'h0);
    chk("lit.rst_ff", 64'(if1.frame_full), 64'h0);
    for (int k = 1; k < WD1; k++) begin
      step();
      chk("lit.rst_ff_low", 64'(if1.frame_full), 64'h0);
    end
    step();
    chk("lit.rst_ff_high", 64'(if1.frame_full), 64'h1);
    for (int c = 0; c < 600; c++) begin
      d0 = 1'($urandom);
      d1 = 4'($urandom);
      de = ($urandom_range(0, 9) == 0);
      ctl = 2'($urandom);
      qe = ($urandom_range(0, 4) == 0);
      core_r = ($urandom_range(0, 3) == 0) ? '0 : (32'h1 << $urandom_range(0, 31));
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_io_shell.md
Name: serial_io_shell

Overview:
Parametrised pin-limited I/O shell for timing-closure builds of wide datapath cores (cycle, round and contgen-driven engines). It deserialises LANES input pins into a WIDTH-bit operand and latches a CTL_W-bit control word for the core. It captures the WIDTH-bit core result into a keep-attributed register and reduces it to one output pin, so synthesis cannot prune the core. It is the multi-lane, auto-framing, resettable generalisation of the single-bit wrapper used on earlier cores.

Parameters:
WIDTH, 32, core operand/result width in bits (>=2)
LANES, 1, serial input bits per cycle (1..WIDTH)
CTL_W, 2, control bits latched alongside the operand (>=1)
AUTO_LOAD, 0, 1 = generate the load strobe internally when a full word has been shifted in

Ports:
clk  in  1  sole clock, all logic on posedge
reset  in  1  synchronous, active-high reset
d  in  LANES  serial operand bits; lane 0 is the newest LSB
de  in  1  operand/control load enable
ctl  in  CTL_W  control bits sampled on load
qe  in  1  result capture enable
core_din  out  WIDTH  latched operand to the core
core_ctl  out  CTL_W  latched control to the core
din_stb  out  1  one-cycle pulse: core_din/core_ctl updated this cycle
core_r  in  WIDTH  core result
frame_full  out  1  shift register holds >= WORDS new groups since last load
q  out  1  reduced result pin

Behaviour:
- WORDS = ceil(WIDTH/LANES). Localparam CNT_W = clog2(WORDS+1).
- Shift register dd[WIDTH-1:0]: every cycle dd <= {dd[WIDTH-1-LANES:0], d}. When LANES=WIDTH, dd <= d.
- fill_cnt counts shifted groups, saturating at WORDS. frame_full = (fill_cnt == WORDS), combinational from the register.
- Load strobe ld = de | (AUTO_LOAD & frame_full). On ld: core_din <= dd (pre-shift value, so the d presented on the ld cycle is excluded) and core_ctl <= ctl.
- On ld, fill_cnt <= 1 (the group shifted that cycle counts toward the next frame). Otherwise fill_cnt <= sat(fill_cnt+1).
- de and the auto strobe in the same cycle: a single load, no double count.
- din_stb <= ld (registered). It is high in the cycle core_din shows its new value.
- Capture: qe -> qq <= core_r. qq carries keep attribute. qe and ld in the same cycle are independent.
- Output, default build: q <= |qq every cycle. Latency is qe edge -> qq (1) -> q (2 cycles).
- Reset, synchronous: dd=0, fill_cnt=0, core_din=0, core_ctl=0, din_stb=0, qq=0, q=0.
- Reset dominates de/qe in the same cycle. Reset mid-frame discards the partial frame; frame_full reasserts only after WORDS further cycles.
- WIDTH not a multiple of LANES: the top bits of dd drop off. The frame is still WORDS groups, and the oldest group is partially truncated.

Optional Feature:
SERIAL_IO_SHELL_SHIFT_OUT_EN
- Defined: qq is a shift-out register. qe loads core_r; otherwise qq <= qq >> 1 every cycle. q <= qq[0], so result bit i appears on q at cycle qe+1+i. After WIDTH cycles qq is zero and q=0. A qe during a shift restarts from the new value.
- Undefined: OR-reduce as above, no shifting.

Decomposition:
- Package serial_io_shell_pkg: clog2-based WORDS/CNT_W helper functions and the saturating-increment function.
- One natural sub-module, serial_io_deser: dd, fill_cnt, frame_full and ld generation. The capture/output stage stays in the top.

Test Plan:
- LANES=1, WIDTH=32: shift 0xDEADBEEF MSB-first over 32 cycles, de on cycle 33 -> core_din=0xDEADBEEF, din_stb high one cycle later, core_ctl=ctl.
- LANES=4, AUTO_LOAD=1, WIDTH=32: stream nibbles 0x1..0x8 -> frame_full after 8 cycles; auto load gives core_din=0x12345678; the next frame's counter starts at 1.
- de asserted while frame_full with AUTO_LOAD=1 -> exactly one din_stb pulse and fill_cnt=1.
- core_r=0x00010000, qe pulse -> q=1 two cycles later. core_r=0, qe -> q=0 two cycles later.
- Reset asserted with fill_cnt=5 and de high -> no load, all outputs 0 next cycle, frame_full low for WORDS cycles.
- SERIAL_IO_SHELL_SHIFT_OUT_EN, core_r=0xA5 (WIDTH=8), qe -> q sequence 1,0,1,0,0,1,0,1 from cycle qe+1, then 0.
